// File: rtl/cntwithen_bank_if.sv
// Control/status bundle for cntwithen_bank: per-channel strobes and load
// values in, packed counts and terminal-count pulses out.
interface cntwithen_bank_if #(
   parameter int BITWIDTH = 4,
   parameter int CHANNELS = 4
);
   logic [CHANNELS-1:0]          iEn;
   logic [CHANNELS-1:0]          iClr;
   logic [CHANNELS-1:0]          iDir;
   logic [CHANNELS-1:0]          iLoad;
   logic [CHANNELS*BITWIDTH-1:0] iLoadVal;
   logic [CHANNELS*BITWIDTH-1:0] oCnt;
   logic [CHANNELS-1:0]          oTc;
   logic                         oTcAll;

   // Driving side (sequencer / bench).
   modport master (
      output iEn, iClr, iDir, iLoad, iLoadVal,
      input  oCnt, oTc, oTcAll
   );

   // Counter bank side.
   modport slave (
      input  iEn, iClr, iDir, iLoad, iLoadVal,
      output oCnt, oTc, oTcAll
   );
endinterface

// File: rtl/cntwithen_bank.sv
// Bank of independent enable-gated modulo counters. Each channel supports
// clear, clamped load, up/down stepping, wrap or saturate at the boundary and
// a one-cycle terminal-count pulse. Channel k lives at bits
// [k*BITWIDTH +: BITWIDTH] of the packed count/load buses.
// MODULUS must lie in 2..2**BITWIDTH; codes at or above MODULUS are never
// reached because loads clamp and steps wrap or saturate at MODULUS-1.
module cntwithen_bank #(
   parameter int BITWIDTH = 4,
   parameter int CHANNELS = 4,
   parameter int MODULUS  = 2**BITWIDTH,
   parameter int SATURATE = 0
) (
   input logic              iClk,
   input logic              iRstN,
   cntwithen_bank_if.slave  bus
);

   localparam logic [BITWIDTH-1:0] MAX_CNT = BITWIDTH'(MODULUS - 1);
   localparam logic [BITWIDTH-1:0] ONE     = BITWIDTH'(1);

   logic [CHANNELS-1:0][BITWIDTH-1:0] cntQ;
   logic [CHANNELS-1:0][BITWIDTH-1:0] cntD;
   logic [CHANNELS-1:0]               tcQ;
   logic [CHANNELS-1:0]               tcD;
   logic                              tcAllQ;

   // Next count and terminal flag for one channel, returned as {tc, count}.
   // Priority is clear, then load, then enabled step.
   function automatic logic [BITWIDTH:0] stepCh(
      input logic [BITWIDTH-1:0] cur,
      input logic                clr,
      input logic                load,
      input logic                en,
      input logic                dir,
      input logic [BITWIDTH-1:0] loadVal
   );
      logic [BITWIDTH-1:0] nxt;
      logic                tc;
      nxt = cur;
      tc  = 1'b0;
      if (clr) begin
         nxt = '0;
      end else if (load) begin
         nxt = (loadVal > MAX_CNT) ? MAX_CNT : loadVal;
      end else if (en) begin
         if (dir) begin
            if (cur == MAX_CNT) begin
               tc  = 1'b1;
               nxt = (SATURATE != 0) ? MAX_CNT : '0;
            end else begin
               nxt = cur + ONE;
            end
         end else begin
            if (cur == '0) begin
               tc  = 1'b1;
               nxt = (SATURATE != 0) ? '0 : MAX_CNT;
            end else begin
               nxt = cur - ONE;
            end
         end
      end
      return {tc, nxt};
   endfunction

   // Evaluate every channel's next state independently.
   always_comb begin
      cntD = cntQ;
      tcD  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         {tcD[k], cntD[k]} = stepCh(cntQ[k], bus.iClr[k], bus.iLoad[k],
                                    bus.iEn[k], bus.iDir[k],
                                    bus.iLoadVal[k*BITWIDTH +: BITWIDTH]);
      end
   end

   // Register counts, pulses and the all-channels pulse; reset clears all.
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         cntQ   <= '0;
         tcQ    <= '0;
         tcAllQ <= 1'b0;
      end else begin
         cntQ   <= cntD;
         tcQ    <= tcD;
         tcAllQ <= &tcD;
      end
   end

   assign bus.oCnt   = cntQ;
   assign bus.oTc    = tcQ;
   assign bus.oTcAll = tcAllQ;

endmodule

// File: tb/tb_cntwithen_bank.sv
// Bench for cntwithen_bank: a wrap-mode bank (MODULUS=10) and a saturate-mode
// bank (MODULUS=16) share one stimulus stream; both are compared every cycle
// against an arithmetic reference model, with directed spot checks on top.
module tb_cntwithen_bank;

   localparam int BW = 4;
   localparam int CH = 4;

   logic clk;
   logic rstN;
   logic [CH-1:0]    en, clr, dir, load;
   logic [CH*BW-1:0] lv;

   int vectors;
   int miscompares;

   int mCnt [2][CH];
   bit mTc  [2][CH];
   bit mAll [2];
   int modv [2];
   bit satv [2];

   logic [CH*BW-1:0] cntArr [2];
   logic [CH-1:0]    tcArr  [2];
   logic             allArr [2];

   cntwithen_bank_if #(.BITWIDTH(BW), .CHANNELS(CH)) ifW ();
   cntwithen_bank_if #(.BITWIDTH(BW), .CHANNELS(CH)) ifS ();

   assign ifW.iEn = en;  assign ifW.iClr = clr; assign ifW.iDir = dir;
   assign ifW.iLoad = load; assign ifW.iLoadVal = lv;
   assign ifS.iEn = en;  assign ifS.iClr = clr; assign ifS.iDir = dir;
   assign ifS.iLoad = load; assign ifS.iLoadVal = lv;

   assign cntArr[0] = ifW.oCnt; assign tcArr[0] = ifW.oTc; assign allArr[0] = ifW.oTcAll;
   assign cntArr[1] = ifS.oCnt; assign tcArr[1] = ifS.oTc; assign allArr[1] = ifS.oTcAll;

   cntwithen_bank #(.BITWIDTH(BW), .CHANNELS(CH), .MODULUS(10), .SATURATE(0)) dutW (
      .iClk(clk), .iRstN(rstN), .bus(ifW.slave));
   cntwithen_bank #(.BITWIDTH(BW), .CHANNELS(CH), .MODULUS(16), .SATURATE(1)) dutS (
      .iClk(clk), .iRstN(rstN), .bus(ifS.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: one step of a modulo counter with clamp on load.
   task automatic refStep(input int cnt, input bit c, input bit l, input int v,
                          input bit e, input bit up, input int m, input bit sat,
                          output int nCnt, output bit tc);
      tc   = 0;
      nCnt = cnt;
      if (c) nCnt = 0;
      else if (l) nCnt = (v > m - 1) ? m - 1 : v;
      else if (e) begin
         tc   = up ? (cnt == m - 1) : (cnt == 0);
         nCnt = (cnt + m + (up ? 1 : -1)) % m;
         if (sat && tc) nCnt = cnt;
      end
   endtask

   task automatic modelEdge();
      for (int d = 0; d < 2; d++) begin
         mAll[d] = 1;
         for (int k = 0; k < CH; k++) begin
            if (!rstN) begin
               mCnt[d][k] = 0;
               mTc[d][k]  = 0;
            end else begin
               refStep(mCnt[d][k], clr[k], load[k], int'(lv[k*BW +: BW]), en[k], dir[k],
                       modv[d], satv[d], mCnt[d][k], mTc[d][k]);
            end
            mAll[d] = mAll[d] & mTc[d][k];
         end
      end
   endtask

   task automatic checkAll(input string tag);
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < CH; k++) begin
            chk($sformatf("%s d%0d cnt%0d", tag, d, k), 32'(cntArr[d][k*BW +: BW]), mCnt[d][k]);
            chk($sformatf("%s d%0d tc%0d", tag, d, k), 32'(tcArr[d][k]), 32'(mTc[d][k]));
         end
         chk($sformatf("%s d%0d tcAll", tag, d), 32'(allArr[d]), 32'(mAll[d]));
      end
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      modelEdge();
      #1;
      checkAll(tag);
   endtask

   task automatic idle();
      en = '0; clr = '0; dir = '0; load = '0; lv = '0;
   endtask

   function automatic logic [BW-1:0] getCnt(input int d, input int k);
      return cntArr[d][k*BW +: BW];
   endfunction

   initial begin
      vectors = 0; miscompares = 0;
      modv[0] = 10; satv[0] = 0;
      modv[1] = 16; satv[1] = 1;
      for (int d = 0; d < 2; d++) begin
         mAll[d] = 0;
         for (int k = 0; k < CH; k++) begin mCnt[d][k] = 0; mTc[d][k] = 0; end
      end
      idle();
      rstN = 1'b0;
      en = '1; dir = '1;
      cycle("reset");
      cycle("reset");
      #2 rstN = 1'b1;
      idle();
      for (int i = 0; i < 3; i++) cycle("hold");

      // Wrap up on ch0.
      en[0] = 1'b1; dir[0] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cycle("wrapUp");
         chk("wrapUp seqW", 32'(getCnt(0, 0)), (i + 1) % 10);
         chk("wrapUp tcW", 32'(tcArr[0][0]), (i == 9) ? 1 : 0);
      end
      idle();

      // Load 2 then count down into the boundary.
      load[0] = 1'b1; lv[3:0] = 4'd2;
      cycle("loadDown");
      idle();
      en[0] = 1'b1; dir[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle("downSat");
         chk("downSat seqS", 32'(getCnt(1, 0)), (i == 0) ? 1 : 0);
         chk("downSat tcS", 32'(tcArr[1][0]), (i >= 2) ? 1 : 0);
      end
      dir[0] = 1'b1;
      cycle("upAway");
      chk("upAway cntS", 32'(getCnt(1, 0)), 1);
      chk("upAway tcS", 32'(tcArr[1][0]), 0);
      idle();

      // Priority on ch1.
      load[1] = 1'b1; lv[7:4] = 4'd3;
      cycle("prioPre");
      clr[1] = 1'b1; load[1] = 1'b1; en[1] = 1'b1; dir[1] = 1'b1; lv[7:4] = 4'd7;
      cycle("prioClr");
      chk("prioClr cntW", 32'(getCnt(0, 1)), 0);
      chk("prioClr tcW", 32'(tcArr[0][1]), 0);
      clr[1] = 1'b0;
      cycle("prioLoad");
      chk("prioLoad cntW", 32'(getCnt(0, 1)), 7);
      chk("prioLoad cntS", 32'(getCnt(1, 1)), 7);
      idle();

      // Load clamp on ch2.
      load[2] = 1'b1; lv[11:8] = 4'd13;
      cycle("clamp");
      chk("clamp cntW", 32'(getCnt(0, 2)), 9);
      chk("clamp cntS", 32'(getCnt(1, 2)), 13);
      idle();
      en[2] = 1'b1; dir[2] = 1'b1;
      cycle("clampStep");
      chk("clampStep cntW", 32'(getCnt(0, 2)), 0);
      chk("clampStep tcW", 32'(tcArr[0][2]), 1);
      chk("clampStep cntS", 32'(getCnt(1, 2)), 14);
      idle();

      // All channels at the top, stepping up together.
      load = '1; lv = '1;
      cycle("allLoad");
      idle();
      en = '1; dir = '1;
      cycle("allTc");
      chk("allTc W", 32'(allArr[0]), 1);
      chk("allTc S", 32'(allArr[1]), 1);
      chk("allTc tcW", 32'(tcArr[0]), 32'hF);
      idle();
      load = '1; lv = '1;
      cycle("allLoad2");
      idle();
      en = 4'b1011; dir = '1;
      cycle("partTc");
      chk("partTc W", 32'(allArr[0]), 0);
      chk("partTc S", 32'(allArr[1]), 0);
      chk("partTc ch2W", 32'(getCnt(0, 2)), 9);
      chk("partTc ch2S", 32'(getCnt(1, 2)), 15);
      idle();

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         en  = 4'($urandom);
         dir = 4'($urandom);
         lv  = 16'($urandom);
         for (int k = 0; k < CH; k++) begin
            clr[k]  = ($urandom_range(7) == 0);
            load[k] = ($urandom_range(5) == 0);
         end
         cycle("rand");
      end
      idle();

      // Asynchronous reset in the middle of a run.
      load = '1; lv = 16'h5555;
      cycle("preRst");
      idle();
      en = '1; dir = '1;
      cycle("preRstRun");
      #2 rstN = 1'b0;
      #1;
      chk("asyncRst cntW", 32'(cntArr[0]), 0);
      chk("asyncRst cntS", 32'(cntArr[1]), 0);
      chk("asyncRst tcW", 32'(tcArr[0]), 0);
      chk("asyncRst allW", 32'(allArr[0]), 0);
      for (int d = 0; d < 2; d++) begin
         mAll[d] = 0;
         for (int k = 0; k < CH; k++) begin mCnt[d][k] = 0; mTc[d][k] = 0; end
      end
      cycle("inRst");
      #2 rstN = 1'b1;
      idle();
      cycle("postRst");
      cycle("postRst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cntwithen_bank.md
# cntwithen_bank

Parametrised bank of independent enable-gated counters. It extends the single-channel enable/clear counter with:
- multiple channels
- programmable modulus
- up/down direction
- synchronous load
- wrap or saturate mode
- a per-channel terminal-count pulse

It sits in front of the stochastic bitstream generators (rng_insert path) and provides per-channel position/sequence indices, with boundary events used to frame bitstream periods.

## Interface

Parameters:
- BITWIDTH, 4, width of each channel count.
- CHANNELS, 4, number of independent counters.
- MODULUS, 2**BITWIDTH, count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**BITWIDTH.
- SATURATE, 0, boundary behaviour: 0 wraps, 1 holds at the boundary.

Ports:
- iClk, input, 1, clock; all state updates on the rising edge.
- iRstN, input, 1, asynchronous active-low reset.
- iEn, input, CHANNELS, per-channel count enable; one step per enabled cycle.
- iClr, input, CHANNELS, per-channel synchronous clear to 0.
- iDir, input, CHANNELS, per-channel direction: 1 counts up, 0 counts down.
- iLoad, input, CHANNELS, per-channel synchronous load strobe.
- iLoadVal, input, CHANNELS*BITWIDTH, load values; channel k occupies bits [k*BITWIDTH +: BITWIDTH].
- oCnt, output, CHANNELS*BITWIDTH, registered counts, packed the same way as iLoadVal.
- oTc, output, CHANNELS, registered one-cycle terminal-count pulse per channel.
- oTcAll, output, 1, registered; 1 when every bit of oTc would be 1 on the same edge.

## Operation

- Channels are fully independent. No state is shared except oTcAll.
- Per-channel priority at each rising edge: iClr > iLoad > iEn.
- iClr=1:
  - count := 0; oTc := 0.
  - iLoad and iEn are ignored that cycle.
- iLoad=1 (and no iClr):
  - count := min(iLoadVal slice, MODULUS-1); an out-of-range load clamps to MODULUS-1.
  - oTc := 0; iEn is ignored that cycle.
- iEn=1 (no iClr, no iLoad), iDir=1:
  - count < MODULUS-1: count+1, oTc := 0.
  - count == MODULUS-1: count := 0 if SATURATE=0, otherwise it holds at MODULUS-1; oTc := 1 in both modes.
- iEn=1 (no iClr, no iLoad), iDir=0:
  - count > 0: count-1, oTc := 0.
  - count == 0: count := MODULUS-1 if SATURATE=0, otherwise it holds at 0; oTc := 1 in both modes.
- iEn=0, no clr/load: count holds; oTc := 0.
- In saturate mode oTc re-pulses on every enabled cycle spent at the boundary in the direction of travel. Counting away from the boundary proceeds normally.
- Direction may change on any cycle. The sampled iDir applies to that cycle's step only.
- Arithmetic is modulo MODULUS, not 2**BITWIDTH. Counts never leave 0..MODULUS-1 after reset.
- iLoadVal and iDir are don't-care when they are not used in that cycle.

## Timing

- Reset (iRstN=0, asynchronous, any time, including mid-count): oCnt=0, oTc=0, oTcAll=0 immediately.
- Reset release: first state change at the first rising edge with iRstN=1.
- Latency: 1 cycle. Inputs sampled at edge N appear on oCnt/oTc after edge N. No combinational input→output path.
- oTc is high for exactly the cycle following the boundary step. Back-to-back steps at the boundary produce back-to-back pulses.
- oTcAll is a registered AND of the next-state oTc vector and aligns with oTc.
- Simultaneous iClr/iLoad/iEn on one channel resolve by the priority above. Different channels never interact.
- MODULUS < 2**BITWIDTH: the unused upper codes are unreachable. Loads into them clamp.

## Test plan

- Reset/hold: assert iRstN=0 while counts are non-zero, mid-run -> oCnt=0 and oTc=0 asynchronously, before the next edge. With iEn=0 after release, counts stay 0.
- Wrap up, BITWIDTH=4, MODULUS=10, SATURATE=0: ch0 iEn=1, iDir=1 for 12 cycles from 0 -> the sequence is 1..9,0,1,2. oTc[0]=1 only in the cycle oCnt goes 9→0.
- Down/saturate, SATURATE=1, MODULUS=16: load 2, then count down 4 cycles -> 1,0,0,0. oTc pulses on each of the last two cycles. Switching to iDir=1 then gives 1.
- Priority: on ch1 assert iClr=1, iLoad=1 (val 7) and iEn=1 together -> 0, oTc=0. Next cycle iLoad=1 (val 7) with iEn=1 -> 7, not 8.
- Load clamp, MODULUS=10: load 13 -> oCnt=9. Then one up-step -> 0 with oTc=1 (wrap mode).
- Multi-channel/oTcAll, CHANNELS=4: all channels at MODULUS-1 counting up, enabled together -> all oTc=1 and oTcAll=1 for one cycle. Repeat with ch2 disabled -> oTcAll=0 and ch2 unchanged.
